// File: rtl/txs_burst_sched.sv
// txs_burst_sched: round-robin scheduler of 128-bit Avalon-MM burst writes onto the PCIe TXS port
// clk125/npor: clock and asynchronous active-low reset
// enable, ptr_reset: allow new grants; clear ring pointers and burst counters
// req/req_data/ack: three FWFT requesters (req = a full burst is buffered, ack = pop one beat)
// txs_*: Avalon-MM burst master toward the TXS port
// irq_clr/irq/irq_pending: per-requester interrupt every IRQ_EVERY completed bursts
// wr_ptr: next burst index of each requester ring, flattened like req_data
module txs_burst_sched #(
    parameter int BURST_LEN   = 8,
    parameter int ADDR_W      = 22,
    parameter int RING_BURSTS = 8192,
    parameter int PTR_W       = $clog2(RING_BURSTS),
    parameter int IRQ_EVERY   = 64
) (
    input  logic                 clk125,
    input  logic                 npor,
    input  logic                 enable,
    input  logic                 ptr_reset,
    input  logic [2:0]           req,
    input  logic [383:0]         req_data,
    output logic [2:0]           ack,
    output logic [ADDR_W-1:0]    txs_address,
    output logic                 txs_write,
    output logic [5:0]           txs_burstcount,
    output logic [127:0]         txs_writedata,
    input  logic                 txs_waitrequest,
    input  logic [2:0]           irq_clr,
    output logic                 irq,
    output logic [2:0]           irq_pending,
    output logic [3*PTR_W-1:0]   wr_ptr
);
    localparam int OFS   = $clog2(BURST_LEN * 16);
    localparam int CNT_W = $clog2(IRQ_EVERY + 1);
    typedef enum logic {IDLE, BURST} state_t;
    state_t            state, state_n;
    logic [1:0]        grant, last, pick, nx1, nx2;
    logic [5:0]        beat_cnt;
    logic [PTR_W-1:0]  ptr [3];
    logic [CNT_W-1:0]  bcnt [3];
    logic [2:0]        irq_set;
    logic              pend, clr, go, accept, done;
    logic [ADDR_W-1:0] addr_n;
    // A ptr_reset seen mid-burst is remembered in pend and applied once back in IDLE.
    always_comb begin
        nx1     = last == 2'd2 ? 2'd0 : last + 2'd1;
        nx2     = nx1 == 2'd2 ? 2'd0 : nx1 + 2'd1;
        pick    = req[nx1] ? nx1 : req[nx2] ? nx2 : last;
        clr     = ptr_reset | pend;
        go      = state == IDLE && enable && |req && !clr;
        accept  = state == BURST && !txs_waitrequest;
        done    = accept && beat_cnt == 6'(BURST_LEN - 1);
        state_n = state == IDLE ? (go ? BURST : IDLE) : (done ? IDLE : BURST);
        addr_n  = {pick, {(ADDR_W-2){1'b0}}} | (ADDR_W'(ptr[pick]) << OFS);
        for (int i = 0; i < 3; i++)
            irq_set[i] = done && grant == 2'(i) && bcnt[i] == CNT_W'(IRQ_EVERY - 1);
    end
    assign txs_write      = state == BURST;
    assign ack            = accept ? 3'b001 << grant : 3'b000;
    assign txs_burstcount = 6'(BURST_LEN);
    assign txs_writedata  = req_data[128*grant +: 128];
    for (genvar i = 0; i < 3; i++) begin : g_ptr
        assign wr_ptr[PTR_W*i +: PTR_W] = ptr[i];
    end
    always_ff @(posedge clk125 or negedge npor) begin
        if (!npor) begin
            state       <= IDLE;
            grant       <= 2'd0;
            last        <= 2'd2;
            beat_cnt    <= '0;
            txs_address <= '0;
            pend        <= 1'b0;
            irq_pending <= '0;
            irq         <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                ptr[i]  <= '0;
                bcnt[i] <= '0;
            end
        end else begin
            state       <= state_n;
            irq         <= |irq_pending;
            irq_pending <= (irq_pending & ~irq_clr) | irq_set;
            pend        <= state == BURST && (pend || ptr_reset);
            if (go) begin
                grant       <= pick;
                txs_address <= addr_n;
                beat_cnt    <= '0;
            end
            if (accept)
                beat_cnt <= beat_cnt + 6'd1;
            if (done) begin
                last        <= grant;
                ptr[grant]  <= ptr[grant] + 1'b1;
                bcnt[grant] <= irq_set[grant] ? '0 : bcnt[grant] + 1'b1;
            end
            if (state == IDLE && clr)
                for (int i = 0; i < 3; i++) begin
                    ptr[i]  <= '0;
                    bcnt[i] <= '0;
                end
        end
    end
endmodule

// File: doc/txs_burst_sched.md
Name: txs_burst_sched

Overview:
- Schedules 128-bit Avalon-MM burst writes onto the PCIe TXS port of the platform system. Three requesters share the port: camera 0, camera 1 and the IMU.
- Each requester is a first-word-fall-through FIFO that raises req once at least BURST_LEN beats are buffered. The block arbitrates round-robin and generates host ring-buffer addresses per requester.
- It counts completed bursts, raises an interrupt every IRQ_EVERY bursts, and sits between the capture logic and platform_inst in the top-level wrapper.

Parameters:
- BURST_LEN, 8, beats per burst (1..32); drives txs_burstcount.
- ADDR_W, 22, TXS byte-address width.
- RING_BURSTS, 8192, bursts per requester ring; power of two; RING_BURSTS*BURST_LEN*16 <= 2^(ADDR_W-2).
- PTR_W, $clog2(RING_BURSTS), ring pointer width.
- IRQ_EVERY, 64, completed bursts per requester between interrupt requests.

Ports:
- clk125  in  1  PCIe application clock (125 MHz)
- npor  in  1  asynchronous active-low reset
- enable  in  1  allow new grants (from PIO output)
- ptr_reset  in  1  level; clears ring pointers and burst counters
- req  in  3  requester i has >= BURST_LEN beats ready
- req_data  in  384  beat data; requester i on bits [128*i+127:128*i]
- ack  out  3  one-cycle pop strobe to requester i per accepted beat
- txs_address  out  ADDR_W  burst start byte address
- txs_write  out  1  Avalon write
- txs_burstcount  out  6  constant BURST_LEN
- txs_writedata  out  128  current beat
- txs_waitrequest  in  1  Avalon backpressure
- irq_clr  in  3  clear pending interrupt i (level)
- irq  out  1  OR of irq_pending
- irq_pending  out  3  per-requester pending flags
- wr_ptr  out  3*PTR_W  next burst index per requester, flattened like req_data

Behaviour:
- Reset (npor low, async): state IDLE, txs_write=0, ack=0, txs_address=0, irq_pending=0, irq=0, all wr_ptr=0, burst counters=0, beat_cnt=0. Round-robin last-grant=2, so requester 0 has first priority.
- States: IDLE, BURST.
  - IDLE -> BURST when enable && |req.
  - In that transition the grant goes to the first requesting index after last-grant, mod 3.
  - txs_address is latched as {grant[1:0], wr_ptr[grant], (log2(BURST_LEN*16)) zero bits}, zero-extended or truncated to ADDR_W. The ring for requester i starts at i*2^(ADDR_W-2).
  - beat_cnt is set to 0.
- In BURST:
  - txs_write=1; txs_address and txs_burstcount are held constant for the whole burst.
  - txs_writedata = req_data[grant] combinationally.
  - A beat is accepted when txs_write && !txs_waitrequest. In that cycle ack[grant]=1 and beat_cnt increments.
  - On acceptance of beat BURST_LEN-1: wr_ptr[grant] advances by 1 mod RING_BURSTS (wraps RING_BURSTS-1 -> 0), last-grant=grant, state -> IDLE.
- Throughput and latency:
  - One idle cycle between consecutive bursts; peak throughput is BURST_LEN/(BURST_LEN+1) beats/cycle.
  - First txs_write appears one cycle after req is sampled in IDLE.
- enable low or req drop mid-burst: the burst runs to completion (Avalon burst rule); no further grants while enable=0.
- Requester contract: req stays high until granted; the next beat is valid in the cycle after each ack. The block never acks a non-granted requester. ack is never asserted while waitrequest=1.
- ptr_reset:
  - In IDLE it takes effect at the next edge: all wr_ptr=0, burst counters=0, and no grant is issued that cycle.
  - Asserted during BURST, it is deferred until the burst completes.
  - Does not clear irq_pending.
- Interrupts:
  - Burst counter i increments on each completed burst of requester i.
  - When it reaches IRQ_EVERY it wraps to 0 and sets irq_pending[i].
  - irq_clr[i] clears bit i; set and clear in the same cycle -> set wins.
  - irq is registered, one cycle after irq_pending.
- Reset asserted mid-burst: txs_write drops immediately (async); the partial burst is abandoned and pointers are cleared. Host software re-initialises the rings.

Test Plan:
- Single burst: req=3'b001, BURST_LEN=8, no waitrequest -> txs_write high exactly 8 cycles, address 0x000000, ack[0] pulsed 8 times, wr_ptr[0]=1, txs_write low for 1 cycle afterward.
- Round-robin: req=3'b111 held -> grant order 0,1,2,0; addresses 0x000000, 0x100000, 0x200000, 0x000080; exactly 3 idle cycles in the first 4 bursts.
- Backpressure: waitrequest high on beats 0, 3 and 7 for 2 cycles each -> txs_write stays high, address is stable, ack low during stalls, burst takes 14 cycles, data order preserved.
- Ring wrap plus irq: RING_BURSTS=4, IRQ_EVERY=4, 4 bursts from requester 1 -> wr_ptr[1] goes 1,2,3,0; fifth address 0x100000; irq_pending=3'b010 and irq high one cycle later. Asserting irq_clr[1] in the same cycle as the next set leaves the bit set.
- enable drop and ptr_reset mid-burst: deassert enable and pulse ptr_reset at beat 3 -> burst completes 8 beats, then all wr_ptr=0 and no new grant while enable=0.
- Async reset at beat 4: npor low -> txs_write=0 and ack=0 within the same cycle; after release the first burst from requester 0 goes to address 0.
